// File: rtl/fp_conv_pkg.sv
// Shared fp16 / fixed-point constants and types for the float_fixed_conversion group.
package fp_conv_pkg;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;
  localparam int unsigned FP16_BIAS  = 15;
  localparam int unsigned FIX_W      = 44;

  // Largest finite fp16 magnitude; used as the saturation value.
  localparam logic [14:0] FP16_MAX_FIN = 15'h7BFF;

  // Width of a leading-zero count over a FIX_W-bit word (0..FIX_W inclusive).
  localparam int unsigned LZ_W = $clog2(FIX_W + 1);

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

endpackage

// File: rtl/leading_zero_cnt.sv
// Combinational leading-zero counter; an all-zero input yields Width.
module leading_zero_cnt #(
  parameter int unsigned Width = 44,
  localparam int unsigned CntW = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  cnt_o
);

  logic found;

  // Scan from the MSB down; the first set bit fixes the count.
  always_comb begin
    cnt_o = CntW'(Width);
    found = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        cnt_o = CntW'(Width - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_to_float.sv
// 44-bit two's-complement fixed point to fp16, 3-stage valid/ready pipeline.
// Stages: S1 sign/magnitude, S2 leading-zero count, S3 normalise/round/pack.
// Build option FIX2FLT_RNE_EN: round-to-nearest-even; otherwise truncate toward zero.
module fixed_to_float
  import fp_conv_pkg::*;
#(
  parameter int unsigned FRAC_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FIX_W-1:0] fix_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      fp_o,
  output logic             ovf_o
);

  // Subnormal mantissa = mag * 2^(24-FRAC_W); taken from {mag, 20'b0} >> SUB_SH.
  localparam int unsigned SUB_SH      = FRAC_W - 4;
  // Biased exponent before rounding is E_OFS - lz (i.e. (43 - lz) - FRAC_W + 15).
  localparam logic [7:0]  E_OFS       = 8'(FIX_W - 1 + FP16_BIAS - FRAC_W);
`ifdef FIX2FLT_RNE_EN
  localparam logic [63:0]      SUB_STICKY  = (64'd1 << (SUB_SH - 1)) - 64'd1;
  localparam logic [FIX_W-1:0] NORM_STICKY = (44'd1 << (FIX_W - 12)) - 44'd1;
`endif

  logic             adv;
  logic             v1_q, v2_q, v3_q;
  logic             sign1_q, sign2_q;
  logic [FIX_W-1:0] mag1_d, mag1_q, mag2_q;
  logic [LZ_W-1:0]  lz2_d, lz2_q;
  logic             zero2_q;
  fp16_t            fp_d, fp_q;
  logic             ovf_d, ovf_q;

  logic signed [7:0] e_raw, e_fin;
  logic              is_norm;
  logic [9:0]        man_pre;
  logic [10:0]       man_rnd;
  logic              rnd_up;
  logic [63:0]       sub_ext;
`ifdef FIX2FLT_RNE_EN
  logic              guard, sticky;
`endif

  // Every stage advances together whenever the output slot is free or being drained.
  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign fp_o      = fp_q;
  assign ovf_o     = ovf_q;

  // S1: magnitude as 44-bit unsigned, so -2^43 maps to 2^43 without wrapping.
  assign mag1_d = fix_i[FIX_W-1] ? (~fix_i + 44'd1) : fix_i;

  // S1 register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sign1_q <= fix_i[FIX_W-1];
      mag1_q  <= mag1_d;
    end
  end

  leading_zero_cnt #(
    .Width (FIX_W)
  ) u_lzc (
    .data_i (mag1_q),
    .cnt_o  (lz2_d)
  );

  // S2 register: magnitude, leading-zero count and zero flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      mag2_q  <= '0;
      lz2_q   <= '0;
      zero2_q <= 1'b0;
    end else if (adv) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      mag2_q  <= mag1_q;
      lz2_q   <= lz2_d;
      zero2_q <= (mag1_q == '0);
    end
  end

  assign sub_ext = {mag2_q, 20'b0};

  // S3 combinational pack: normalise or denormalise, round, saturate.
  always_comb begin
    e_raw   = $signed(E_OFS - {2'b00, lz2_q});
    is_norm = (e_raw > 8'sd0);
    if (is_norm) begin
      // Leading one lands on bit 43 after the shift; mantissa is the next 10 bits.
      man_pre = 10'((mag2_q << lz2_q) >> (FIX_W - 11));
    end else begin
      man_pre = 10'(sub_ext >> SUB_SH);
    end
    rnd_up = 1'b0;
`ifdef FIX2FLT_RNE_EN
    if (is_norm) begin
      guard  = 1'((mag2_q << lz2_q) >> (FIX_W - 12));
      sticky = |((mag2_q << lz2_q) & NORM_STICKY);
    end else begin
      guard  = 1'(sub_ext >> (SUB_SH - 1));
      sticky = |(sub_ext & SUB_STICKY);
    end
    rnd_up = guard & (sticky | man_pre[0]);
`endif
    man_rnd = {1'b0, man_pre} + {10'b0, rnd_up};
    // A mantissa carry bumps the exponent; a subnormal carry becomes the smallest normal.
    e_fin   = (is_norm ? e_raw : 8'sd0) + $signed({7'b0, man_rnd[10]});

    fp_d.sign = sign2_q;
    fp_d.exp  = e_fin[4:0];
    fp_d.man  = man_rnd[9:0];
    ovf_d     = 1'b0;
    if (zero2_q) begin
      fp_d = '0;
    end else if (e_fin >= 8'sd31) begin
      fp_d  = {sign2_q, FP16_MAX_FIN};
      ovf_d = 1'b1;
    end
  end

  // S3 register drives the outputs; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v3_q  <= 1'b0;
      fp_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v3_q  <= v2_q;
      fp_q  <= fp_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed bench for fixed_to_float (FRAC_W = 24); honours FIX2FLT_RNE_EN for rounding cases.
module tb_fixed_to_float;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] fix_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] fp_o;
  logic        ovf_o;

  int n_chk  = 0;
  int n_pass = 0;

  fixed_to_float #(
    .FRAC_W (24)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fix_i     (fix_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_o      (fp_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Single conversion on an idle pipeline: checks latency, then {ovf, fp}.
  task automatic convert(input string tag, input logic [43:0] fix, input logic [15:0] exp_fp,
                         input logic exp_ovf);
    int lat;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    fix_i    = fix;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 17'(lat), 17'd3);
    chk(tag, {ovf_o, fp_o}, {exp_ovf, exp_fp});
  endtask

  logic [43:0] s_fix [8];
  logic [16:0] s_exp [8];

  initial begin
    int          in_idx;
    int          out_idx;
    int          cyc;
    logic        stalled;
    logic [16:0] held;
    logic        seen;

    s_fix[0] = 44'h000_0100_0000;   s_exp[0] = {1'b0, 16'h3C00};
    s_fix[1] = -(44'd5 << 23);      s_exp[1] = {1'b0, 16'hC100};
    s_fix[2] = 44'd1;               s_exp[2] = {1'b0, 16'h0001};
    s_fix[3] = -44'd1;              s_exp[3] = {1'b0, 16'h8001};
    s_fix[4] = 44'd0;               s_exp[4] = {1'b0, 16'h0000};
    s_fix[5] = 44'd1 << 10;         s_exp[5] = {1'b0, 16'h0400};
    s_fix[6] = 44'd65504 << 24;     s_exp[6] = {1'b0, 16'h7BFF};
    s_fix[7] = 44'h800_0000_0000;   s_exp[7] = {1'b1, 16'hFBFF};

    // Reset state
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    fix_i     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 17'(out_valid), 17'd0);
    chk("rst_fp_ovf", {ovf_o, fp_o}, 17'd0);
    chk("rst_in_ready", 17'(in_ready), 17'd1);
    reset_n = 1'b1;

    // Basic values, small and zero values, subnormal/normal boundary
    convert("one",       44'h000_0100_0000, 16'h3C00, 1'b0);
    convert("neg2p5",    -(44'd5 << 23),    16'hC100, 1'b0);
    convert("lsb",       44'd1,             16'h0001, 1'b0);
    convert("zero",      44'd0,             16'h0000, 1'b0);
    convert("neg_lsb",   -44'd1,            16'h8001, 1'b0);
    convert("sub_max",   44'h3FF,           16'h03FF, 1'b0);
    convert("min_norm",  44'd1 << 10,       16'h0400, 1'b0);
    convert("pow_m10",   44'd1 << 14,       16'h1400, 1'b0);

    // Rounding
    convert("half_even", (44'd1 << 24) + (44'd1 << 13), 16'h3C00, 1'b0);
`ifdef FIX2FLT_RNE_EN
    convert("half_odd",  (44'd1 << 24) + (44'd3 << 13), 16'h3C02, 1'b0);
    convert("rnd_ovf",   44'd65520 << 24,               16'h7BFF, 1'b1);
`else
    convert("half_odd",  (44'd1 << 24) + (44'd3 << 13), 16'h3C01, 1'b0);
    convert("rnd_ovf",   44'd65520 << 24,               16'h7BFF, 1'b0);
`endif

    // Saturation
    convert("max_fin",   44'd65504 << 24,   16'h7BFF, 1'b0);
    convert("pos_sat",   44'h7FF_FFFF_FFFF, 16'h7BFF, 1'b1);
    convert("neg_sat",   44'h800_0000_0000, 16'hFBFF, 1'b1);

    // Streaming under random backpressure
    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    @(posedge clk);
    while (out_idx < 8 && cyc < 300) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (in_idx < 8);
      fix_i     = (in_idx < 8) ? s_fix[in_idx] : 44'd0;
      if (stalled) chk("stall_hold", {ovf_o, fp_o}, held);
      @(negedge clk);
      stalled = out_valid && !out_ready;
      if (stalled) begin
        chk("stall_in_ready", 17'(in_ready), 17'd0);
        held = {ovf_o, fp_o};
      end
      if (out_valid && out_ready) begin
        chk("stream", {ovf_o, fp_o}, s_exp[out_idx]);
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
      cyc++;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 17'(out_idx), 17'd8);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("stream_no_dup", 17'(seen), 17'd0);

    // Mid-stream reset with three items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      fix_i    = s_fix[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    chk("midrst_out_valid", 17'(out_valid), 17'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("midrst_no_stale", 17'(seen), 17'd0);
    convert("post_rst", 44'h000_0100_0000, 16'h3C00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
